// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: state encodings and the NOP word used by benches.
// FETCH_HALT is present only when FETCH_MISALIGN_EN is defined.
package fetch_pkg;

`ifdef FETCH_MISALIGN_EN
    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2,
        FETCH_HALT = 2'd3
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;
`endif

    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry valid/ready output register between fetch and decode.
// Optional fault bit is present only with FETCH_MISALIGN_EN.
module fetch_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic        ready_i,
    input  logic [31:0] insn_i,
    input  logic [31:0] pc_i,
`ifdef FETCH_MISALIGN_EN
    input  logic        fault_i,
    output logic        fault_o,
`endif
    output logic        valid_o,
    output logic [31:0] insn_o,
    output logic [31:0] pc_o
);

    logic        valid_q, valid_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] pc_q, pc_d;
`ifdef FETCH_MISALIGN_EN
    logic        fault_q, fault_d;
`endif

    // Load beats flush so a misaligned-redirect fault entry lands in the redirect cycle.
    always_comb begin
        valid_d = valid_q;
        insn_d  = insn_q;
        pc_d    = pc_q;
`ifdef FETCH_MISALIGN_EN
        fault_d = fault_q;
`endif
        if (load_i) begin
            valid_d = 1'b1;
            insn_d  = insn_i;
            pc_d    = pc_i;
`ifdef FETCH_MISALIGN_EN
            fault_d = fault_i;
`endif
        end else if (flush_i) begin
            valid_d = 1'b0;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            insn_q  <= '0;
            pc_q    <= '0;
`ifdef FETCH_MISALIGN_EN
            fault_q <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            insn_q  <= insn_d;
            pc_q    <= pc_d;
`ifdef FETCH_MISALIGN_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign insn_o  = insn_q;
    assign pc_o    = pc_q;
`ifdef FETCH_MISALIGN_EN
    assign fault_o = fault_q;
`endif

endmodule

// File: rtl/fetch.sv
// RV32I fetch stage: PC, single-outstanding imem read FSM, redirect handling.
// FETCH_MISALIGN_EN adds the insn_fault port and the HALT state for misaligned targets.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        insn_valid,
    input  logic        insn_ready,
`ifdef FETCH_MISALIGN_EN
    output logic        insn_fault,
`endif
    output logic [31:0] insn,
    output logic [31:0] insn_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redirect_target;
    logic         buf_load, buf_flush;
    logic [31:0]  buf_insn, buf_pc;
`ifdef FETCH_MISALIGN_EN
    logic         buf_fault;
    assign redirect_target = redirect_pc;
`else
    assign redirect_target = redirect_pc & ~32'd3;
`endif

    assign imem_req  = (state_q == FETCH_REQ) && (!insn_valid || insn_ready);
    assign imem_addr = pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;
        buf_insn  = imem_rdata;
        buf_pc    = pc_q;
`ifdef FETCH_MISALIGN_EN
        buf_fault = 1'b0;
`endif
        if (redirect_valid) begin
            buf_flush = 1'b1;
            pc_d      = redirect_target;
            // A read still in flight must be swallowed in DROP before new requests go out.
            unique case (state_q)
                FETCH_WAIT: state_d = imem_rvalid ? FETCH_REQ : FETCH_DROP;
                FETCH_REQ:  state_d = (imem_req && imem_gnt) ? FETCH_DROP : FETCH_REQ;
                FETCH_DROP: state_d = FETCH_DROP;
                default:    state_d = FETCH_REQ;
            endcase
`ifdef FETCH_MISALIGN_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_d   = FETCH_HALT;
                buf_load  = 1'b1;
                buf_insn  = '0;
                buf_pc    = redirect_pc;
                buf_fault = 1'b1;
            end
`endif
        end else begin
            unique case (state_q)
                FETCH_REQ: begin
                    if (imem_req && imem_gnt) state_d = FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        buf_load = 1'b1;
                        pc_d     = pc_plus4(pc_q);
                        state_d  = FETCH_REQ;
                    end
                end
                FETCH_DROP: begin
                    if (imem_rvalid) state_d = FETCH_REQ;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .flush_i (buf_flush),
        .ready_i (insn_ready),
        .insn_i  (buf_insn),
        .pc_i    (buf_pc),
`ifdef FETCH_MISALIGN_EN
        .fault_i (buf_fault),
        .fault_o (insn_fault),
`endif
        .valid_o (insn_valid),
        .insn_o  (insn),
        .pc_o    (insn_pc)
    );

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: memory model with configurable latency and a
// scoreboard of expected (pc, insn) pairs popped on each decode handshake.
module tb_fetch;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic [31:0] insn;
    logic [31:0] insn_pc;
`ifdef FETCH_MISALIGN_EN
    logic        insn_fault;
`endif

    fetch #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .insn_valid     (insn_valid),
        .insn_ready     (insn_ready),
`ifdef FETCH_MISALIGN_EN
        .insn_fault     (insn_fault),
`endif
        .insn           (insn),
        .insn_pc        (insn_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    logic [31:0] model_pc = RPC;
    bit          pend_ok = 1'b0;
    int          mem_cnt = 0;
    int          lat = 1;
    bit          stale = 1'b0;
    logic [31:0] mem_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {a[26:2], 7'h13};
    endfunction

    // One clock cycle: sample/score just before the edge, then drive the memory response.
    task automatic tick();
        bit          fire;
        logic [31:0] a;
        exp_t        e;
        #1;
        fire = imem_req && imem_gnt && !rst;
        a    = imem_addr;
        if (!rst && insn_valid && insn_ready && !redirect_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got insn_pc=%h insn=%h, required no delivery", insn_pc, insn);
            end else begin
                e = sb.pop_front();
                pops++;
                $display("deliver pc=%h insn=%h (expected pc=%h insn=%h)", insn_pc, insn, e.pc, e.data);
                if (insn_pc !== e.pc || insn !== e.data) begin
                    errors++;
                    $display("FAIL sb_data: got pc=%h insn=%h, required pc=%h insn=%h", insn_pc, insn, e.pc, e.data);
                end
            end
        end
        if (fire) begin
            checks++;
            if (imem_addr !== model_pc) begin
                errors++;
                $display("FAIL req_addr: got %h, required %h", imem_addr, model_pc);
            end
        end
        if (!rst && imem_rvalid && pend_ok && !redirect_valid) begin
            sb.push_back('{pc: model_pc, data: mem_word(model_pc)});
            model_pc = model_pc + 32'd4;
        end
        if (imem_rvalid) pend_ok = 1'b0;
        if (redirect_valid && !rst) begin
`ifdef FETCH_MISALIGN_EN
            model_pc = redirect_pc;
`else
            model_pc = redirect_pc & ~32'd3;
`endif
            sb.delete();
            pend_ok = 1'b0;
        end
        if (fire) pend_ok = !redirect_valid;
        if (rst) begin
            sb.delete();
            pend_ok  = 1'b0;
            model_pc = RPC;
        end
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (rst) begin
            mem_cnt = 0;
        end else begin
            if (fire) begin
                mem_addr = a;
                mem_cnt  = lat;
            end
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = stale ? 32'hDEAD_BEEF : mem_word(mem_addr);
                    stale       = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", insn_valid); end
        checks++; if (insn !== 32'h0) begin errors++; $display("FAIL rst_insn: got %h required 0", insn); end
        checks++; if (insn_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h required 0", insn_pc); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_req: got %b required 1", imem_req); end
        checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL rst_addr: got %h required %h", imem_addr, RPC); end
    endtask

    task automatic test_first_fetch();
        imem_gnt = 1'b1;
        insn_ready = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ff_wait_req: got %b required 0", imem_req); end
        tick();
        checks++; if (insn_valid !== 1'b1) begin errors++; $display("FAIL ff_valid: got %b required 1", insn_valid); end
        checks++; if (insn !== 32'h0050_0093) begin errors++; $display("FAIL ff_insn: got %h required 00500093", insn); end
        checks++; if (insn_pc !== RPC) begin errors++; $display("FAIL ff_pc: got %h required %h", insn_pc, RPC); end
        checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL ff_next_addr: got %h required 00000104", imem_addr); end
    endtask

    task automatic test_stall();
        insn_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req0: got %b required 0", imem_req); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b0 || insn_valid !== 1'b1 || insn !== 32'h0050_0093 ||
                insn_pc !== RPC || imem_addr !== 32'h104) begin
                errors++;
                $display("FAIL stall_hold: got req=%b v=%b insn=%h pc=%h addr=%h required req=0 v=1 insn=00500093 pc=%h addr=00000104",
                         imem_req, insn_valid, insn, insn_pc, imem_addr, RPC);
            end
        end
        insn_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_release: got %b required 1", imem_req); end
        repeat (3) tick();
    endtask

    task automatic test_gnt_low();
        do_reset();
        imem_gnt = 1'b0;
        insn_ready = 1'b1;
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== RPC) begin
                errors++;
                $display("FAIL gnt_low_hold: got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RPC);
            end
            tick();
        end
        imem_gnt = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL gnt_wait: got req=%b required 0", imem_req); end
        tick();
        checks++; if (insn_valid !== 1'b1 || insn_pc !== RPC) begin errors++; $display("FAIL gnt_deliver: got v=%b pc=%h required v=1 pc=%h", insn_valid, insn_pc, RPC); end
    endtask

    task automatic test_redirect_wait();
        int p0;
        do_reset();
        lat = 2;
        imem_gnt = 1'b1;
        insn_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        stale = 1'b1;
        tick();
        redirect_valid = 1'b0;
        lat = 1;
        checks++; if (insn_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rw_drop: got v=%b req=%b required v=0 req=0", insn_valid, imem_req); end
        tick();
        checks++;
        if (insn_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL rw_resume: got v=%b req=%b addr=%h required v=0 req=1 addr=00000200", insn_valid, imem_req, imem_addr);
        end
        p0 = pops;
        repeat (3) tick();
        checks++; if (pops != p0 + 1) begin errors++; $display("FAIL rw_count: got %0d deliveries required 1", pops - p0); end
    endtask

    task automatic test_redirect_grant();
        do_reset();
        lat = 1;
        imem_gnt = 1'b1;
        insn_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (insn_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL rg_drop: got v=%b req=%b addr=%h required v=0 req=0 addr=00000300", insn_valid, imem_req, imem_addr);
        end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL rg_resume: got req=%b addr=%h required req=1 addr=00000300", imem_req, imem_addr); end
        tick();
        tick();
        checks++;
        if (insn_valid !== 1'b1 || insn_pc !== 32'h300 || insn !== mem_word(32'h300)) begin
            errors++;
            $display("FAIL rg_deliver: got v=%b pc=%h insn=%h required v=1 pc=00000300 insn=%h", insn_valid, insn_pc, insn, mem_word(32'h300));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int p0;
        do_reset();
        lat = 1;
        imem_gnt = 1'b1;
        insn_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        p0 = pops;
        repeat (20) tick();
        checks++; if (pops != p0 + 9) begin errors++; $display("FAIL b2b_rate: got %0d deliveries required 9", pops - p0); end
    endtask

    task automatic test_misalign();
        do_reset();
        lat = 1;
`ifdef FETCH_MISALIGN_EN
        imem_gnt = 1'b1;
        insn_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h202;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (insn_fault !== 1'b1 || insn_valid !== 1'b1 || insn_pc !== 32'h202 || insn !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL mis_fault: got f=%b v=%b pc=%h insn=%h req=%b required f=1 v=1 pc=00000202 insn=0 req=0",
                     insn_fault, insn_valid, insn_pc, insn, imem_req);
        end
        insn_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{pc: 32'h202, data: 32'h0});
            tick();
            sb.delete();
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mis_halt_req: got %b required 0", imem_req); end
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin errors++; $display("FAIL mis_resume: got req=%b addr=%h required req=1 addr=00000400", imem_req, imem_addr); end
        tick();
        tick();
        checks++; if (insn_fault !== 1'b0 || insn_pc !== 32'h400) begin errors++; $display("FAIL mis_clear: got f=%b pc=%h required f=0 pc=00000400", insn_fault, insn_pc); end
        tick();
`else
        imem_gnt = 1'b0;
        insn_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h202;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL mis_align: got req=%b addr=%h required req=1 addr=00000200", imem_req, imem_addr); end
        imem_gnt = 1'b1;
        tick();
        tick();
        checks++; if (insn_pc !== 32'h200 || insn !== mem_word(32'h200)) begin errors++; $display("FAIL mis_deliver: got pc=%h insn=%h required pc=00000200 insn=%h", insn_pc, insn, mem_word(32'h200)); end
        tick();
`endif
    endtask

    task automatic test_drain();
        imem_gnt = 1'b0;
        repeat (4) tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL drain: got %0d undelivered entries required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_gnt_low();
        test_redirect_wait();
        test_redirect_grant();
        test_back_to_back();
        test_misalign();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
